asyn_fifo_rd_packer: RTL and testbench



---
 rtl/asyn_fifo_pkg.sv | 18 +
 rtl/asyn_fifo_rd_packer.sv | 122 ++++++++++++
 tb/tb_asyn_fifo_rd_packer.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/asyn_fifo_pkg.sv
// rtl/asyn_fifo_pkg.sv - shared types and helpers for the async FIFO read-side blocks
//
// Purpose: holds the default FIFO word width, the FIFO word type, and the
// helper that sizes the packer's word-count output.
// Ports: none (package).

package asyn_fifo_pkg;

   localparam int DSIZE = 8;

   typedef logic [DSIZE-1:0] word_t;

   // out_cnt has to represent 1..ratio, so it needs one bit more than the lane index.
   function automatic int cnt_w(input int ratio);
      return $clog2(ratio) + 1;
   endfunction

endpackage

// File: rtl/asyn_fifo_rd_packer.sv
// rtl/asyn_fifo_rd_packer.sv - packs RATIO popped FIFO words into one wide valid/ready beat
//
// Purpose: read-domain consumer of the async FIFO. It pops first-word-fall-through
// words, gathers RATIO of them into one beat (word 0 in the LSBs) and holds that beat
// in a registered output stage. A flush pulse pushes out a partially filled beat.
// Ports:
//   rclk, rrst          read clock, synchronous active-high reset
//   rdata, rempty       FIFO read data / empty flag
//   rinc                FIFO pop strobe (combinational)
//   flush               single-cycle request to emit the partial beat
//   out_data, out_cnt   packed beat and number of valid words in it
//   out_valid, out_ready  output handshake
//   flush_pend          flush accepted but not yet emitted

module asyn_fifo_rd_packer
   import asyn_fifo_pkg::*;
#(
   parameter int DSIZE = asyn_fifo_pkg::DSIZE,  // must match word_t
   parameter int RATIO = 4                      // >= 2
) (
   input  logic                      rclk,
   input  logic                      rrst,
   input  logic [DSIZE-1:0]          rdata,
   input  logic                      rempty,
   output logic                      rinc,
   input  logic                      flush,
   output logic [DSIZE*RATIO-1:0]    out_data,
   output logic [cnt_w(RATIO)-1:0]   out_cnt,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic                      flush_pend
);

   localparam int CNTW = $clog2(RATIO);
   localparam int OCW  = cnt_w(RATIO);
   localparam logic [CNTW-1:0] LAST = CNTW'(RATIO - 1);

   // Only RATIO-1 lanes are stored: the last word of a full beat goes
   // straight from rdata into the output register.
   word_t                   lanes_q [RATIO-1];
   word_t                   lanes_d [RATIO-1];
   logic [CNTW-1:0]         cnt_q, cnt_d;
   logic [DSIZE*RATIO-1:0]  out_data_q, out_data_d;
   logic [OCW-1:0]          out_cnt_q, out_cnt_d;
   logic                    out_valid_q, out_valid_d;
   logic                    flush_pend_q, flush_pend_d;

   logic                    slot_free;
   logic                    pop;
   logic                    emit;
   logic                    load;
   logic [OCW-1:0]          words;
   logic [DSIZE*RATIO-1:0]  beat;

   always_comb begin
      slot_free = !out_valid_q || out_ready;
      // With the last lane index reached the word can only be taken if the
      // output register can accept the completed beat this cycle.
      pop   = !rempty && !rrst && ((cnt_q != LAST) || slot_free);
      words = OCW'(cnt_q) + OCW'(pop);

      // Candidate beat: stored lanes below cnt, then this cycle's word, zero above.
      beat = '0;
      for (int i = 0; i < RATIO - 1; i++) begin
         if (CNTW'(i) < cnt_q) beat[i*DSIZE +: DSIZE] = lanes_q[i];
      end
      if (pop) beat[cnt_q*DSIZE +: DSIZE] = rdata;

      // A pending flush with nothing accumulated just retires quietly.
      emit = flush_pend_q && slot_free && (words != '0);
      load = (pop && (cnt_q == LAST)) || emit;

      lanes_d      = lanes_q;
      cnt_d        = cnt_q;
      out_data_d   = out_data_q;
      out_cnt_d    = out_cnt_q;
      out_valid_d  = out_valid_q;
      flush_pend_d = flush_pend_q;

      if (out_valid_q && out_ready) out_valid_d = 1'b0;

      if (load) begin
         out_data_d  = beat;
         out_cnt_d   = words;
         out_valid_d = 1'b1;
         cnt_d       = '0;
      end else if (pop) begin
         for (int i = 0; i < RATIO - 1; i++) begin
            if (CNTW'(i) == cnt_q) lanes_d[i] = rdata;
         end
         cnt_d = cnt_q + CNTW'(1);
      end

      if (flush_pend_q) flush_pend_d = !slot_free;
      else              flush_pend_d = flush && ((cnt_q != '0) || pop);
   end

   always_ff @(posedge rclk) begin
      if (rrst) begin
         for (int i = 0; i < RATIO - 1; i++) lanes_q[i] <= '0;
         cnt_q        <= '0;
         out_data_q   <= '0;
         out_cnt_q    <= '0;
         out_valid_q  <= 1'b0;
         flush_pend_q <= 1'b0;
      end else begin
         lanes_q      <= lanes_d;
         cnt_q        <= cnt_d;
         out_data_q   <= out_data_d;
         out_cnt_q    <= out_cnt_d;
         out_valid_q  <= out_valid_d;
         flush_pend_q <= flush_pend_d;
      end
   end

   assign rinc       = pop;
   assign out_data   = out_data_q;
   assign out_cnt    = out_cnt_q;
   assign out_valid  = out_valid_q;
   assign flush_pend = flush_pend_q;

endmodule

// File: tb/tb_asyn_fifo_rd_packer.sv
// tb/tb_asyn_fifo_rd_packer.sv - directed self-checking bench for asyn_fifo_rd_packer

module tb_asyn_fifo_rd_packer;

   logic        rclk = 1'b0;
   logic        rrst;
   logic [7:0]  rdata;
   logic        rempty;
   logic        rinc;
   logic        flush;
   logic [31:0] out_data;
   logic [2:0]  out_cnt;
   logic        out_valid;
   logic        out_ready;
   logic        flush_pend;

   int total = 0;
   int bad   = 0;
   int pops  = 0;
   logic rinc_s = 1'b0;
   logic [7:0] fifo [$];

   asyn_fifo_rd_packer #(.DSIZE(8), .RATIO(4)) dut (
      .rclk       (rclk),
      .rrst       (rrst),
      .rdata      (rdata),
      .rempty     (rempty),
      .rinc       (rinc),
      .flush      (flush),
      .out_data   (out_data),
      .out_cnt    (out_cnt),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .flush_pend (flush_pend)
   );

   always #5 rclk = ~rclk;

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive_fifo();
      rempty = (fifo.size() == 0);
      rdata  = (fifo.size() == 0) ? 8'h00 : fifo[0];
   endtask

   task automatic push(input logic [7:0] w);
      fifo.push_back(w);
      drive_fifo();
   endtask

   // Sample rinc before the edge, then let the FIFO model pop after it.
   task automatic tick();
      @(negedge rclk);
      rinc_s = rinc;
      @(posedge rclk);
      #1;
      if (rinc_s && fifo.size() != 0) begin
         void'(fifo.pop_front());
         pops++;
      end
      drive_fifo();
   endtask

   initial begin
      rrst = 1'b1; flush = 1'b0; out_ready = 1'b1;
      drive_fifo();
      tick(); tick();

      // Reset state, and no popping while in reset even with data present.
      push(8'h11); push(8'h22); push(8'h33); push(8'h44);
      #1;
      check("rst_rinc", {31'd0, rinc}, 32'd0);
      tick();
      check("rst_valid", {31'd0, out_valid}, 32'd0);
      check("rst_data", out_data, 32'd0);
      check("rst_cnt", {29'd0, out_cnt}, 32'd0);
      check("rst_pend", {31'd0, flush_pend}, 32'd0);
      check("rst_nopop", pops, 0);

      // Single full beat.
      rrst = 1'b0;
      pops = 0;
      for (int i = 0; i < 20 && !out_valid; i++) tick();
      check("b1_valid", {31'd0, out_valid}, 32'd1);
      check("b1_data", out_data, 32'h44332211);
      check("b1_cnt", {29'd0, out_cnt}, 32'd4);
      check("b1_pops", pops, 4);
      tick();
      check("b1_valid_1cyc", {31'd0, out_valid}, 32'd0);

      // Continuous stream of 8 words: beats after pop 4 and pop 8.
      for (int i = 1; i <= 8; i++) push(8'(i));
      for (int i = 1; i <= 8; i++) begin
         tick();
         check("s_rinc", {31'd0, rinc_s}, 32'd1);
         check("s_valid", {31'd0, out_valid}, {31'd0, (i == 4 || i == 8)});
         if (i == 4) check("s_data1", out_data, 32'h04030201);
      end
      check("s_data2", out_data, 32'h08070605);
      tick();
      check("s_idle", {31'd0, out_valid}, 32'd0);

      // Back-pressure: hold the first beat, accumulate three more words, stall.
      push(8'h11); push(8'h22); push(8'h33); push(8'h44);
      push(8'h55); push(8'h66); push(8'h77); push(8'h88);
      pops = 0;
      for (int i = 0; i < 4; i++) tick();
      check("bp_first", out_data, 32'h44332211);
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      check("bp_pops", pops, 7);
      check("bp_stall_rinc", {31'd0, rinc}, 32'd0);
      check("bp_hold_valid", {31'd0, out_valid}, 32'd1);
      check("bp_hold_data", out_data, 32'h44332211);
      out_ready = 1'b1;
      #1;
      check("bp_release_rinc", {31'd0, rinc}, 32'd1);
      tick();
      check("bp_b2b_valid", {31'd0, out_valid}, 32'd1);
      check("bp_second", out_data, 32'h88776655);
      check("bp_second_cnt", {29'd0, out_cnt}, 32'd4);
      check("bp_pops_total", pops, 8);
      tick();
      check("bp_done", {31'd0, out_valid}, 32'd0);

      // Flush of a two-word partial beat.
      push(8'hAA); push(8'hBB);
      tick(); tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check("fl_pend", {31'd0, flush_pend}, 32'd1);
      check("fl_novalid", {31'd0, out_valid}, 32'd0);
      tick();
      check("fl_valid", {31'd0, out_valid}, 32'd1);
      check("fl_data", out_data, 32'h0000BBAA);
      check("fl_cnt", {29'd0, out_cnt}, 32'd2);
      check("fl_pend_clr", {31'd0, flush_pend}, 32'd0);
      tick();

      // Flush with nothing accumulated and an empty FIFO is ignored.
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check("fl0_pend", {31'd0, flush_pend}, 32'd0);
      tick();
      check("fl0_valid", {31'd0, out_valid}, 32'd0);

      // Flush in a pop cycle, and a further pop folded into the emitted beat.
      push(8'hC1);
      tick();
      push(8'hC2);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check("flp_pend", {31'd0, flush_pend}, 32'd1);
      push(8'hC3);
      tick();
      check("flp_valid", {31'd0, out_valid}, 32'd1);
      check("flp_data", out_data, 32'h00C3C2C1);
      check("flp_cnt", {29'd0, out_cnt}, 32'd3);
      tick();

      // Reset with cnt=3 and a held beat.
      push(8'h11); push(8'h22); push(8'h33); push(8'h44);
      for (int i = 0; i < 4; i++) tick();
      out_ready = 1'b0;
      push(8'h55); push(8'h66); push(8'h77);
      for (int i = 0; i < 3; i++) tick();
      check("mr_held", {31'd0, out_valid}, 32'd1);
      rrst = 1'b1;
      push(8'hA1); push(8'hA2); push(8'hA3); push(8'hA4);
      pops = 0;
      tick();
      check("mr_valid", {31'd0, out_valid}, 32'd0);
      check("mr_data", out_data, 32'd0);
      check("mr_nopop", pops, 0);
      rrst = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 20 && !out_valid; i++) tick();
      check("mr_clean", out_data, 32'hA4A3A2A1);
      check("mr_clean_cnt", {29'd0, out_cnt}, 32'd4);
      check("mr_pops", pops, 4);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
